// File: rtl/local_global_predictor_pkg.sv
// Constants and helpers shared by the branch predictor and its counter logic.
package local_global_predictor_pkg;

  // Instructions are word aligned, so PC bits below this are never used for indexing.
  localparam int unsigned PC_ALIGN_BITS = 2;

  function automatic int unsigned ctr_weak_not_taken(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter_next.sv
// Next-state function of a saturating up/down counter: never wraps past
// zero or the all-ones maximum.
module bp_sat_counter_next #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) ctr_next = ctr + 1'b1;
    end else begin
      if (ctr != '0) ctr_next = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/sys_defs.svh
// Shared definitions for the fetch-stage predictor: machine word width,
// predictor mode encodings and the optional debug snapshot type.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`ifndef XLEN
`define XLEN 32
`endif

`define BP_MODE_PAG    0
`define BP_MODE_GSHARE 1

`ifdef DEBUG
typedef struct packed {
  logic [31:0] ghr;
  logic [31:0] last_idx;
} BP_DEBUG;
`endif

`endif

// File: rtl/local_global_predictor.sv
// Two-level direction predictor: per-address local history (PAg) or
// gshare with speculative global history and mispredict recovery.
`include "sys_defs.svh"

module local_global_predictor
  import local_global_predictor_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned HIST_BITS   = 8,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned MODE        = `BP_MODE_PAG
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lookup_valid,
  input  logic [`XLEN-1:0]     lookup_pc,
  output logic                 predict_taken,
  output logic [HIST_BITS-1:0] predict_hist,
  input  logic                 update_valid,
  input  logic [`XLEN-1:0]     update_pc,
  input  logic [HIST_BITS-1:0] update_hist,
  input  logic                 update_taken,
  input  logic                 update_mispredict
`ifdef DEBUG
  ,
  output BP_DEBUG              bp_debug
`endif
);

  localparam int unsigned BHT_IDX_BITS = $clog2(BHT_ENTRIES);
  localparam int unsigned PHT_ENTRIES  = 32'd1 << HIST_BITS;
  localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

  logic [CTR_BITS-1:0]  pht_q [PHT_ENTRIES];
  logic [HIST_BITS-1:0] lookup_idx;
  logic [HIST_BITS-1:0] update_idx;
  logic [CTR_BITS-1:0]  update_ctr_d;

  // Inputs that one of the modes leaves unused; upper PC bits never index.
  logic unused_inputs;
  assign unused_inputs = ^{lookup_valid, lookup_pc, update_pc, update_hist, update_mispredict};

  assign predict_taken = pht_q[lookup_idx][CTR_BITS-1];

  bp_sat_counter_next #(
    .CTR_BITS(CTR_BITS)
  ) u_ctr_next (
    .ctr     (pht_q[update_idx]),
    .taken   (update_taken),
    .ctr_next(update_ctr_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_RESET;
    end else if (update_valid) begin
      pht_q[update_idx] <= update_ctr_d;
    end
  end

  generate
    if (MODE == `BP_MODE_GSHARE) begin : g_gshare
      logic [HIST_BITS-1:0] ghr_q;
      logic [HIST_BITS-1:0] ghr_d;

      assign predict_hist = ghr_q;
      assign lookup_idx   = ghr_q ^ lookup_pc[PC_ALIGN_BITS +: HIST_BITS];
      assign update_idx   = update_hist ^ update_pc[PC_ALIGN_BITS +: HIST_BITS];

      // Recovery beats the speculative shift: the concurrent lookup is younger and squashed.
      always_comb begin
        ghr_d = ghr_q;
        if (update_valid && update_mispredict) begin
          ghr_d = {update_hist[HIST_BITS-2:0], update_taken};
        end else if (lookup_valid) begin
          ghr_d = {ghr_q[HIST_BITS-2:0], predict_taken};
        end
      end

      always_ff @(posedge clock) begin
        if (reset) ghr_q <= '0;
        else       ghr_q <= ghr_d;
      end
    end else begin : g_pag
      logic [HIST_BITS-1:0]    bht_q [BHT_ENTRIES];
      logic [BHT_IDX_BITS-1:0] lookup_bht_idx;
      logic [BHT_IDX_BITS-1:0] update_bht_idx;
      logic [HIST_BITS-1:0]    update_bht_hist;

      assign lookup_bht_idx  = lookup_pc[PC_ALIGN_BITS +: BHT_IDX_BITS];
      assign update_bht_idx  = update_pc[PC_ALIGN_BITS +: BHT_IDX_BITS];
      assign predict_hist    = bht_q[lookup_bht_idx];
      assign lookup_idx      = predict_hist;
      assign update_bht_hist = bht_q[update_bht_idx];
      assign update_idx      = update_bht_hist;

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= '0;
        end else if (update_valid) begin
          bht_q[update_bht_idx] <= {update_bht_hist[HIST_BITS-2:0], update_taken};
        end
      end
    end
  endgenerate

`ifdef DEBUG
  logic [HIST_BITS-1:0] last_idx_q;

  always_ff @(posedge clock) begin
    if (reset)             last_idx_q <= '0;
    else if (lookup_valid) last_idx_q <= lookup_idx;
  end

  assign bp_debug.ghr      = (MODE == `BP_MODE_GSHARE) ? 32'(predict_hist) : 32'd0;
  assign bp_debug.last_idx = 32'(last_idx_q);
`endif

endmodule

// File: tb/tb_local_global_predictor.sv
// Drives a PAg and a gshare predictor with identical stimulus and checks both
// against array-based reference models of the prediction and training rules.
`include "sys_defs.svh"

module tb_local_global_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [7:0]  update_hist;
  logic        update_taken;
  logic        update_mispredict;

  logic        pag_taken, gs_taken;
  logic [7:0]  pag_hist, gs_hist;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain integer counters and histories.
  int m_bht   [64];
  int m_pht_p [256];
  int m_pht_g [256];
  int m_ghr;

  always #5 clock = ~clock;

  local_global_predictor #(
    .BHT_ENTRIES(64), .HIST_BITS(8), .CTR_BITS(2), .MODE(`BP_MODE_PAG)
  ) dut_pag (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_taken(pag_taken), .predict_hist(pag_hist),
    .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
    .update_taken(update_taken), .update_mispredict(update_mispredict)
  );

  local_global_predictor #(
    .BHT_ENTRIES(64), .HIST_BITS(8), .CTR_BITS(2), .MODE(`BP_MODE_GSHARE)
  ) dut_gs (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_taken(gs_taken), .predict_hist(gs_hist),
    .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
    .update_taken(update_taken), .update_mispredict(update_mispredict)
  );

  function automatic int sat(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    foreach (m_bht[i])   m_bht[i] = 0;
    foreach (m_pht_p[i]) m_pht_p[i] = 1;
    foreach (m_pht_g[i]) m_pht_g[i] = 1;
    m_ghr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int ph, gi;
    ph = m_bht[int'((lookup_pc >> 2) & 32'd63)];
    gi = m_ghr ^ int'((lookup_pc >> 2) & 32'd255);
    chk({tag, ".pag_hist"},  32'(pag_hist),  32'(ph));
    chk({tag, ".pag_taken"}, 32'(pag_taken), (m_pht_p[ph] >= 2) ? 32'd1 : 32'd0);
    chk({tag, ".gs_hist"},   32'(gs_hist),   32'(m_ghr));
    chk({tag, ".gs_taken"},  32'(gs_taken),  (m_pht_g[gi] >= 2) ? 32'd1 : 32'd0);
  endtask

  task automatic drive(input bit lv, input logic [31:0] pc, input bit uv,
                       input logic [31:0] upc, input logic [7:0] uh,
                       input bit ut, input bit um);
    lookup_valid      = lv;
    lookup_pc         = pc;
    update_valid      = uv;
    update_pc         = upc;
    update_hist       = uh;
    update_taken      = ut;
    update_mispredict = um;
    #1;
  endtask

  // Advance one clock and apply the same cycle to the reference model.
  task automatic tick();
    int  bi, h, gi;
    bit  g_pred;
    g_pred = m_pht_g[m_ghr ^ int'((lookup_pc >> 2) & 32'd255)] >= 2;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (update_valid) begin
        bi = int'((update_pc >> 2) & 32'd63);
        h  = m_bht[bi];
        m_pht_p[h] = sat(m_pht_p[h], update_taken);
        m_bht[bi]  = ((h << 1) | int'(update_taken)) & 255;
        gi = int'(update_hist) ^ int'((update_pc >> 2) & 32'd255);
        m_pht_g[gi] = sat(m_pht_g[gi], update_taken);
      end
      if (update_valid && update_mispredict)
        m_ghr = ((int'(update_hist) << 1) | int'(update_taken)) & 255;
      else if (lookup_valid)
        m_ghr = ((m_ghr << 1) | int'(g_pred)) & 255;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
          8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    model_reset();

    // Reset state, both modes
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("rst.pag_taken", 32'(pag_taken), 32'd0);
    chk("rst.pag_hist",  32'(pag_hist),  32'h00);
    chk("rst.gs_taken",  32'(gs_taken),  32'd0);
    chk("rst.gs_hist",   32'(gs_hist),   32'h00);
    tick();

    // Gshare saturation: 1 -> 2 -> 3 -> 3, then down to 2
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h100, 8'h00, 1'b1, 1'b0);
      check_model("sat_up");
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h100, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("sat.gs_taken", 32'(gs_taken), 32'd1);
    chk("sat.gs_hist",  32'(gs_hist),  32'h00);
    check_model("sat");
    tick();

    // Reset in the middle of training
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("midrst.gs_taken",  32'(gs_taken),  32'd0);
    chk("midrst.gs_hist",   32'(gs_hist),   32'h00);
    chk("midrst.pag_taken", 32'(pag_taken), 32'd0);
    chk("midrst.pag_hist",  32'(pag_hist),  32'h00);
    tick();

    // PAg history build-up on pc 0x104
    repeat (2) begin
      drive(1'b0, 32'h0, 1'b1, 32'h104, 8'h00, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 32'h104, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("pag.hist",  32'(pag_hist),  32'h03);
    chk("pag.taken", 32'(pag_taken), 32'd0);

    // Same-entry collision: lookup sees the pre-update value
    drive(1'b1, 32'h104, 1'b1, 32'h104, 8'h00, 1'b1, 1'b0);
    chk("coll.old_hist",  32'(pag_hist),  32'h03);
    chk("coll.old_taken", 32'(pag_taken), 32'd0);
    check_model("coll");
    tick();
    drive(1'b1, 32'h104, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("coll.new_hist",  32'(pag_hist),  32'h07);
    chk("coll.new_taken", 32'(pag_taken), 32'd0);
    check_model("coll_next");
    tick();

    // Gshare recovery wins over a same-cycle speculative shift
    do_reset();
    drive(1'b1, 32'h200, 1'b1, 32'h300, 8'h05, 1'b1, 1'b1);
    check_model("recov");
    tick();
    drive(1'b0, 32'h200, 1'b0, 32'h300, 8'h55, 1'b0, 1'b1);
    chk("recov.gs_hist", 32'(gs_hist), 32'h0B);
    check_model("recov_next");
    tick();
    drive(1'b0, 32'h200, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("nouv.gs_hist", 32'(gs_hist), 32'h0B);
    tick();

    // Randomized traffic over a small PC set to force aliasing and collisions
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      drive(1'($urandom_range(0, 1)),
            (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)),
            1'($urandom_range(0, 2) != 0),
            (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1) ? 8'(m_ghr) : 8'($urandom),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
      check_model("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
